// File: rtl/uart_rx_ctrl_if.sv
// Receive-side handshake bundle: received word with valid/ready, plus status.
// The master end (the controller) drives data and status; the slave end drives rx_ready.
interface uart_rx_ctrl_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 busy;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output busy,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  busy,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start qualification, mid-bit sampling, LSB-first shift, stop check,
// and a valid/ready holding register with framing and overrun pulses.
module uart_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           rx_sync,
    uart_rx_ctrl_if.master rx
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(DATA_BITS + 1);

    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        // A pending word is consumed on any edge where the consumer is ready.
        valid_d = valid_q & ~rx.rx_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_sync) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == FullLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LastBit) begin
                        bit_d   = '0;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StStop: begin
                if (cnt_q == FullLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (!rx_sync) begin
                        ferr_d = 1'b1;
                    end else if (!valid_q || rx.rx_ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.busy      = (state_q != StIdle);
    assign rx.frame_err = ferr_q;
    assign rx.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a timing model keyed on elapsed cycles since the start edge is
// compared with the DUT every cycle, plus literal expectations for the directed scenarios.
module tb_uart_rx_ctrl;
    localparam int C  = 16;
    localparam int DB = 8;
    localparam int H  = C / 2;
    localparam int STOP_D = H + (DB + 1) * C;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic rx_sync = 1'b1;

    uart_rx_ctrl_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_ctrl #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (DB)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .rx_sync(rx_sync),
        .rx     (rx_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a frame is a start edge at t0; everything else is a fixed offset from it.
    bit            m_active = 1'b0;
    int            t0 = 0;
    int            d;
    logic          vpre;
    logic [DB-1:0] m_bits = '0;
    logic [DB-1:0] m_data = '0;
    logic          m_valid = 1'b0;
    logic          m_fe = 1'b0;
    logic          m_ov = 1'b0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_active = 1'b0;
            m_data   = '0;
            m_valid  = 1'b0;
            m_fe     = 1'b0;
            m_ov     = 1'b0;
        end else begin
            vpre = m_valid;
            m_fe = 1'b0;
            m_ov = 1'b0;
            if (vpre && rx_if.rx_ready) m_valid = 1'b0;
            if (!m_active) begin
                if (!rx_sync) begin
                    m_active = 1'b1;
                    t0 = cyc;
                end
            end else begin
                d = cyc - t0;
                if (d == H) begin
                    if (rx_sync) m_active = 1'b0;
                end else if (d == STOP_D) begin
                    m_active = 1'b0;
                    if (!rx_sync) m_fe = 1'b1;
                    else if (!vpre || rx_if.rx_ready) begin
                        m_data  = m_bits;
                        m_valid = 1'b1;
                    end else m_ov = 1'b1;
                end else if (d > H && (d - H) % C == 0) begin
                    m_bits[(d - H) / C - 1] = rx_sync;
                end
            end
        end
    end

    // Event trackers for literal checks; edge index of an observation is cyc-1.
    logic prev_valid = 1'b0;
    logic prev_busy  = 1'b0;
    int   rise_cnt = 0, last_rise = -1;
    int   fe_cnt = 0, last_fe = -1;
    int   ov_cnt = 0;
    int   last_busy_fall = -1;

    always @(negedge clk) begin
        chk("rx_valid", 32'(rx_if.rx_valid), 32'(m_valid));
        chk("rx_data", 32'(rx_if.rx_data), 32'(m_data));
        chk("busy", 32'(rx_if.busy), 32'(m_active));
        chk("frame_err", 32'(rx_if.frame_err), 32'(m_fe));
        chk("overrun", 32'(rx_if.overrun), 32'(m_ov));
        if (rx_if.rx_valid === 1'b1 && prev_valid !== 1'b1) begin
            rise_cnt++;
            last_rise = cyc - 1;
        end
        if (rx_if.frame_err === 1'b1) begin
            fe_cnt++;
            last_fe = cyc - 1;
        end
        if (rx_if.overrun === 1'b1) ov_cnt++;
        if (rx_if.busy === 1'b0 && prev_busy === 1'b1) last_busy_fall = cyc - 1;
        prev_valid = rx_if.rx_valid;
        prev_busy  = rx_if.busy;
    end

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            rx_sync = 1'b1;
            rx_if.rx_ready = rdy;
            @(posedge clk);
            #1;
        end
        rx_if.rx_ready = 1'b0;
    endtask

    // Drives one full frame; ts is the edge that sees the start bit.
    task automatic send(input logic [DB-1:0] b, input logic stop, input logic rdy,
                        input int ready_k, input int rst_k, output int ts);
        int bi;
        ts = cyc;
        for (int k = 0; k < (DB + 2) * C; k++) begin
            bi = k / C;
            if (bi == 0) rx_sync = 1'b0;
            else if (bi <= DB) rx_sync = b[bi-1];
            else rx_sync = stop;
            rx_if.rx_ready = (k == ready_k) ? 1'b1 : rdy;
            if (k == rst_k) begin
                nrst = 1'b0;
                @(posedge clk);
                #1;
                nrst = 1'b1;
                rx_sync = 1'b1;
                rx_if.rx_ready = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        rx_sync = 1'b1;
        rx_if.rx_ready = 1'b0;
    endtask

    int ts, ts2, fe0, rise0, ov0;

    initial begin
        rx_if.rx_ready = 1'b0;
        @(posedge clk);
        #1;
        // Reset held with the line toggling.
        for (int i = 0; i < 10; i++) begin
            rx_sync = i[0];
            @(posedge clk);
            #1;
        end
        chk("reset_busy", 32'(rx_if.busy), 32'd0);
        chk("reset_valid", 32'(rx_if.rx_valid), 32'd0);
        rx_sync = 1'b1;
        nrst = 1'b1;
        idle(5, 1'b0);
        chk("post_reset_pulses", 32'(fe_cnt + ov_cnt + rise_cnt), 32'd0);

        // Single frame 0xA5, consumer not ready.
        send(8'hA5, 1'b1, 1'b0, -1, -1, ts);
        idle(20, 1'b0);
        chk("a5_rise_offset", 32'(last_rise - ts), 32'd152);
        chk("a5_data", 32'(rx_if.rx_data), 32'hA5);
        chk("a5_held", 32'(rx_if.rx_valid), 32'd1);
        idle(1, 1'b1);
        chk("a5_cleared", 32'(rx_if.rx_valid), 32'd0);

        // Glitch shorter than half a bit.
        rise0 = rise_cnt;
        fe0 = fe_cnt;
        ts = cyc;
        for (int i = 0; i < 4; i++) begin
            rx_sync = 1'b0;
            @(posedge clk);
            #1;
        end
        idle(20, 1'b0);
        chk("glitch_idle_at", 32'(last_busy_fall - ts), 32'd8);
        chk("glitch_no_valid", 32'(rise_cnt - rise0), 32'd0);
        chk("glitch_no_ferr", 32'(fe_cnt - fe0), 32'd0);

        // Framing error on 0x3C, then a clean 0x81.
        fe0 = fe_cnt;
        send(8'h3C, 1'b0, 1'b0, -1, -1, ts);
        idle(20, 1'b0);
        chk("ferr_offset", 32'(last_fe - ts), 32'd152);
        chk("ferr_count", 32'(fe_cnt - fe0), 32'd1);
        chk("ferr_no_valid", 32'(rx_if.rx_valid), 32'd0);
        send(8'h81, 1'b1, 1'b0, -1, -1, ts);
        idle(10, 1'b0);
        chk("after_ferr_data", 32'(rx_if.rx_data), 32'h81);
        chk("after_ferr_valid", 32'(rx_if.rx_valid), 32'd1);
        idle(1, 1'b1);

        // Overrun: second back-to-back frame dropped.
        ov0 = ov_cnt;
        send(8'h11, 1'b1, 1'b0, -1, -1, ts);
        send(8'h22, 1'b1, 1'b0, -1, -1, ts2);
        idle(10, 1'b0);
        chk("ovr_offset", 32'(ts2 - ts), 32'd160);
        chk("ovr_count", 32'(ov_cnt - ov0), 32'd1);
        chk("ovr_kept_data", 32'(rx_if.rx_data), 32'h11);
        chk("ovr_valid", 32'(rx_if.rx_valid), 32'd1);
        idle(1, 1'b1);

        // Accept on the second stop-sample edge: new word replaces the old one.
        ov0 = ov_cnt;
        send(8'h11, 1'b1, 1'b0, -1, -1, ts);
        send(8'h22, 1'b1, 1'b0, STOP_D, -1, ts2);
        idle(10, 1'b0);
        chk("swap_no_ovr", 32'(ov_cnt - ov0), 32'd0);
        chk("swap_data", 32'(rx_if.rx_data), 32'h22);
        chk("swap_valid", 32'(rx_if.rx_valid), 32'd1);
        idle(1, 1'b1);

        // Reset during data bit 4, then a clean 0x5A.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rise0 = rise_cnt;
        send(8'h96, 1'b1, 1'b0, -1, H + 5 * C - 4, ts);
        idle(40, 1'b0);
        chk("midrst_busy", 32'(rx_if.busy), 32'd0);
        chk("midrst_no_out", 32'(rise_cnt - rise0 + fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
        send(8'h5A, 1'b1, 1'b0, -1, -1, ts);
        idle(10, 1'b0);
        chk("midrst_data", 32'(rx_if.rx_data), 32'h5A);
        chk("midrst_rise_offset", 32'(last_rise - ts), 32'd152);
        idle(1, 1'b1);
        idle(200, 1'b0);
        chk("midrst_once", 32'(rise_cnt - rise0), 32'd1);
        chk("midrst_drained", 32'(rx_if.rx_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
